// File: rtl/fir_filter_pkg.sv
// Shared constants, sample/coefficient/accumulator types and the
// default coefficient set for the streaming FIR filter.
package fir_filter_pkg;

    localparam int TAPS   = 16;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef coef_t coef_array_t [TAPS];

    // 16-tap moving average: each tap weighs 1/16 in Q1.15
    localparam coef_array_t DEFAULT_COEFFS = '{default: coef_t'(16'sh0800)};

endpackage

// File: rtl/fir_filter_if.sv
// Sample stream bundle: one input sample and one filtered
// output sample per clock, no handshake.
interface fir_filter_if
    import fir_filter_pkg::*;
#(
    parameter int W = DATA_W
);
    logic signed [W-1:0] inData;
    logic signed [W-1:0] outData;

    modport master (output inData, input outData);
    modport slave (input inData, output outData);
endinterface

// File: rtl/fir_round_sat.sv
// Combinational Q-format rescale of the accumulator: round half up,
// arithmetic shift, then clamp to the signed sample range.
module fir_round_sat #(
    parameter int ACC_W  = 36,
    parameter int DATA_W = 16,
    parameter int FRAC   = 15
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y
);

    localparam logic signed [ACC_W-1:0] HALF =
        {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;

    // round, rescale and clamp so the output never wraps
    always_comb begin
        sum     = acc + HALF;
        shifted = sum >>> FRAC;
        if (shifted > MAXV) begin
            y = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < MINV) begin
            y = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            y = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/fir_filter.sv
// Streaming direct-form FIR: delay line, single-cycle MAC sum and
// a registered, rounded and saturated output. Latency is 2 edges.
module fir_filter
    import fir_filter_pkg::*;
#(
    parameter int TAPS   = fir_filter_pkg::TAPS,
    parameter int DATA_W = fir_filter_pkg::DATA_W,
    parameter int COEF_W = fir_filter_pkg::COEF_W,
    parameter logic signed [COEF_W-1:0] COEFFS [TAPS] = DEFAULT_COEFFS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] inData,
    output logic signed [DATA_W-1:0] outData
);

    localparam int PW   = DATA_W + COEF_W;
    localparam int AW   = PW + $clog2(TAPS);

    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [PW-1:0]     prod [TAPS];
    logic signed [AW-1:0]     acc;
    logic signed [DATA_W-1:0] y;

    // delay line: newest sample in x[0], older ones shift up
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x[k] <= '0;
            end
        end else begin
            x[0] <= inData;
            for (int k = 1; k < TAPS; k++) begin
                x[k] <= x[k-1];
            end
        end
    end

    // full-precision products summed with no intermediate truncation
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            prod[k] = PW'(x[k]) * PW'(COEFFS[k]);
            acc     = acc + AW'(prod[k]);
        end
    end

    fir_round_sat #(
        .ACC_W  (AW),
        .DATA_W (DATA_W),
        .FRAC   (COEF_W - 1)
    ) u_round_sat (
        .acc (acc),
        .y   (y)
    );

    // registered output, cleared immediately on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outData <= '0;
        end else begin
            outData <= y;
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Randomized bench for fir_filter: default moving-average instance and
// a saturating all-0x7FFF instance, checked against an arithmetic model.
module tb_fir_filter;
    import fir_filter_pkg::*;

    logic clk;
    logic reset;

    fir_filter_if sif ();
    fir_filter_if sat_if ();

    fir_filter dut (
        .clk     (clk),
        .reset   (reset),
        .inData  (sif.inData),
        .outData (sif.outData)
    );

    fir_filter #(
        .COEFFS ('{default: 16'sh7FFF})
    ) dut_sat (
        .clk     (clk),
        .reset   (reset),
        .inData  (sat_if.inData),
        .outData (sat_if.outData)
    );

    int n_chk;
    int n_pass;

    longint hist [TAPS];
    longint exp_avg;
    longint exp_sat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_y(input longint c);
        longint acc;
        longint y;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            acc += c * hist[k];
        end
        y = (acc + 16384) >>> 15;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    // one clock: present din, advance the model, compare at negedge
    task automatic tick(input logic signed [15:0] din, input string tag);
        sif.inData    = din;
        sat_if.inData = din;
        @(posedge clk);
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) hist[k] = 0;
            exp_avg = 0;
            exp_sat = 0;
        end else begin
            exp_avg = ref_y(2048);
            exp_sat = ref_y(32767);
            for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = longint'(din);
        end
        @(negedge clk);
        check({tag, "_avg"}, longint'(sif.outData), exp_avg);
        check({tag, "_sat"}, longint'(sat_if.outData), exp_sat);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(16'($urandom), "rst_hold");
            check("rst_zero", longint'(sif.outData), 0);
        end
        reset = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        for (int k = 0; k < TAPS; k++) hist[k] = 0;
        reset         = 1'b0;
        sif.inData    = '0;
        sat_if.inData = '0;
        #2;
        check("rst_async", longint'(sif.outData), 0);

        do_reset();
        for (int i = 0; i < 5; i++) tick(16'sh0000, "zero");

        // impulse: 1024 on 16 cycles starting 2 edges after the sample
        tick(16'sh4000, "imp_in");
        for (int i = 0; i < 20; i++) begin
            tick(16'sh0000, "imp");
            check("imp_const", longint'(sif.outData),
                  (i < TAPS) ? 1024 : 0);
        end

        // DC step to 1000
        do_reset();
        for (int i = 0; i < 24; i++) tick(16'sd1000, "dc");
        check("dc_settle", longint'(sif.outData), 1000);

        // extremes, incl. saturation on the 0x7FFF instance
        for (int i = 0; i < 20; i++) tick(16'sh7FFF, "pmax");
        check("pmax_settle", longint'(sif.outData), 32767);
        check("pmax_sat", longint'(sat_if.outData), 32767);
        for (int i = 0; i < 20; i++) tick(16'sh8000, "nmax");
        check("nmax_settle", longint'(sif.outData), -32768);
        check("nmax_sat", longint'(sat_if.outData), -32768);

        // ramp with a short reset pulse between edges
        for (int i = 0; i < 150; i++) begin
            tick(16'(i % 100), "ramp");
            if (i == 60) begin
                #1 reset = 1'b0;
                #1;
                check("mid_rst_avg", longint'(sif.outData), 0);
                check("mid_rst_sat", longint'(sat_if.outData), 0);
                #2 reset = 1'b1;
                for (int k = 0; k < TAPS; k++) hist[k] = 0;
            end
        end

        // random stream
        for (int i = 0; i < 300; i++) tick(16'($urandom), "rand");

        // random small-amplitude stream
        for (int i = 0; i < 100; i++) begin
            tick(16'($signed(12'($urandom))), "rand_small");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fir_filter.md
# fir_filter

Streaming 16-tap direct-form FIR filter, one signed 16-bit sample in and one filtered signed 16-bit sample out on every clock. There is no handshake. It sits in the signal path between a sample source and downstream DSP or DAC logic. It runs continuously at the system clock rate. Coefficients are fixed at elaboration; the default set is a 16-tap moving-average low-pass.

## Interface
- TAPS, 16, number of taps (≥2).
- DATA_W, 16, sample width, signed two's complement, Q1.15.
- COEF_W, 16, coefficient width, signed Q1.15.
- COEFFS, 16 × 16'sh0800, coefficient array indexed 0..TAPS-1; tap 0 multiplies the newest sample.
- clk  input  1  system clock, rising-edge active.
- reset  input  1  reset; one clock, asynchronous and active-low. Clears all state while low.
- inData  input  DATA_W  input sample; sampled on every rising clk edge.
- outData  output  DATA_W  filtered sample, registered.
- Port order for positional instantiation: clk, reset, inData, outData.

## Operation
- The delay line x[0..TAPS-1] is DATA_W signed.
- Each edge: x[0] takes inData and x[k] takes x[k-1].
- Accumulator: acc = Σ COEFFS[k]·x[k]. Each product is full-precision DATA_W+COEF_W bits, sign-extended to ACC_W = DATA_W+COEF_W+clog2(TAPS) = 36 bits. No intermediate truncation.
- Scaling: y = (acc + 2^14) >>> 15, an arithmetic shift with round-half-up.
- Saturation: y is clamped to [-32768, 32767] before it is registered.
- Each edge: outData takes the saturated y computed from the current delay-line contents.
- There is no valid or enable signal; every clock is a sample.
- Reset (reset = 0): all x[k] = 0 and outData = 0 immediately, independent of clk. Both hold at 0 while reset stays low.
- Reset release: operation resumes on the first rising edge with reset = 1. History is zero-filled, so outputs ramp in exactly as from power-up.
- Reset asserted mid-stream: partial results are discarded; no residue from pre-reset samples may appear afterwards.

## Timing
- Latency is 2 edges. A sample present on inData before edge n enters x[0] at edge n and first contributes to outData at edge n+1.
- Impulse response: it occupies outData for TAPS consecutive cycles, starting at edge n+1.
- Throughput is 1 sample per clock.
- Critical path: 16 multiplies plus the adder tree in one cycle.
- Pipelining the adder tree is not permitted; latency is fixed at 2.
- outData changes only on a rising clk edge or on reset assertion.

## Structure
- Package fir_filter_pkg holds:
  - TAPS, DATA_W, COEF_W and ACC_W constants.
  - typedefs sample_t, coef_t and acc_t.
  - coef_array_t.
  - the default coefficient constant DEFAULT_COEFFS.
- One sub-module, fir_round_sat, contains the combinational acc_t → sample_t rounding and saturation.
- The top level holds the delay line, the MAC sum and the output register.

## Test plan
- Reset: hold reset = 0 with random inData -> outData = 0 and stays 0. Release, then feed 0 -> outData remains 0.
- Impulse: after reset, feed 16'h4000 for one cycle, then 0 -> outData = 1024 on 16 consecutive cycles starting 2 edges after the sample, then 0.
- DC step: feed constant 1000 -> outData ramps 62/63, 125, … in 1000/16 increments and settles at 1000 from the 16th output onward.
- Extremes: constant 16'h7FFF -> settles at 32767. Constant 16'h8000 -> settles at -32768. No wrap-around at any point.
- Mid-stream reset: stream a 100-sample repeating ramp 0..99. Pulse reset low mid-stream for 3 ns between edges -> outData goes to 0 at once. Post-release outputs equal a fresh ramp-in with zero history.
- Saturation: instantiate with COEFFS all 16'sh7FFF and feed constant 16'h7FFF -> outData clamps to 32767. Feed constant 16'h8000 -> outData clamps to -32768.
